volt_cal_multi: RTL and testbench

Parametrised successor to the two-channel ADC voltage converter. It takes NCH packed offset-binary ADC samples and averages 2^AVG_LOG2 samples per channel. Each averaged sample is converted to a sign character and a magnitude in millivolts, and the magnitude is turned into packed BCD by one shared sequential double-dabble engine. Sits between the ADC capture logic and the character/LCD display formatter, in the ad_clk domain.

---
 rtl/volt_cal_pkg.sv | 34 +++
 rtl/bcd_seq.sv | 61 ++++++
 rtl/volt_cal_multi.sv | 164 ++++++++++++++++
 tb/tb_volt_cal_multi.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/volt_cal_pkg.sv
// Shared types and helpers for the multi-channel ADC-to-millivolt converter.
// Sign characters, conversion FSM states and elaboration-time math.
package volt_cal_pkg;

    localparam logic [7:0] ASCII_PLUS  = 8'd43;
    localparam logic [7:0] ASCII_MINUS = 8'd45;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_SCALE,
        ST_SHIFT,
        ST_STORE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, BIN_W cycles from start; done_o marks the last step.
// No backpressure: start_i restarts the engine, and digits above DIGITS are dropped.
module bcd_seq
    import volt_cal_pkg::*;
#(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  done_o,
    output logic [DIGITS*4-1:0]   dec_o
);

    localparam int CW = clog2(BIN_W + 1);

    logic [DIGITS*4-1:0] dig_q, dig_d, src_dig, adj;
    logic [BIN_W-1:0]    sr_q, sr_d, src_sr;
    logic [CW-1:0]       cnt_q, cnt_d, src_cnt;
    logic                run;

    // The first step is taken in the start cycle itself, straight from bin_i.
    always_comb begin
        src_dig = start_i ? '0 : dig_q;
        src_sr  = start_i ? bin_i : sr_q;
        src_cnt = start_i ? '0 : cnt_q;
        run     = start_i || (cnt_q != '0);
        adj     = src_dig;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        done_o = run && (src_cnt == CW'(BIN_W - 1));
        dig_d  = dig_q;
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        if (run) begin
            dig_d = {adj[DIGITS*4-2:0], src_sr[BIN_W-1]};
            sr_d  = src_sr << 1;
            cnt_d = done_o ? '0 : src_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dig_q <= '0;
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            dig_q <= dig_d;
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign dec_o = dig_q;

endmodule

// File: rtl/volt_cal_multi.sv
// Averages 2^AVG_LOG2 ADC samples per channel, converts to sign + BCD mV; out_valid 1+NCH*(MV_W+2) cycles after block end.
// Never stalls the ADC: a block completing while the converter is busy is dropped with an overrun pulse.
module volt_cal_multi
    import volt_cal_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int AD_W       = 12,
    parameter int FS_MV      = 5000,
    parameter int AVG_LOG2   = 2,
    parameter int BCD_DIGITS = 5
) (
    input  logic                         ad_clk,
    input  logic                         rst_n,
    input  logic                         ad_valid,
    input  logic [NCH*AD_W-1:0]          ad_data,
    output logic [NCH*BCD_DIGITS*4-1:0]  ch_dec,
    output logic [NCH*8-1:0]             ch_sig,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int MV_W   = clog2(FS_MV + 1);
    localparam int ACC_W  = AD_W + AVG_LOG2;
    localparam int PROD_W = AD_W + MV_W;
    localparam int DW     = BCD_DIGITS * 4;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int CH_W   = (NCH > 1) ? clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] LAST_SMP  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [AD_W-1:0]  HALF_CODE = {1'b1, {(AD_W-1){1'b0}}};

    if (pow10(BCD_DIGITS) <= longint'(FS_MV)) begin : g_digits_chk
        $error("BCD_DIGITS cannot represent FS_MV");
    end

    state_t              state_q;
    logic [CH_W-1:0]     c_q;
    logic [MV_W-1:0]     mv_q, mv_d;
    logic [7:0]          sig_q, sig_d;
    logic                shift_first_q;
    logic [NCH*DW-1:0]   ch_dec_q;
    logic [NCH*8-1:0]    ch_sig_q;
    logic                out_valid_q, overrun_q;
    logic [CNT_W-1:0]    smp_cnt_q;
    logic [ACC_W-1:0]    acc_q  [NCH];
    logic [ACC_W-1:0]    sum_d  [NCH];
    logic [AD_W-1:0]     mean_d [NCH];
    logic [AD_W-1:0]     snap_q [NCH];
    logic [AD_W-1:0]     sel, mag;
    logic [PROD_W-1:0]   prod;
    logic                blk_done, accept, bcd_done;
    logic [DW-1:0]       bcd_dec;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            sum_d[k]  = acc_q[k] + ACC_W'(ad_data[k*AD_W +: AD_W]);
            mean_d[k] = AD_W'(sum_d[k] >> AVG_LOG2);
        end
        blk_done = ad_valid && (smp_cnt_q == LAST_SMP);
        // The out_valid cycle still counts as busy for an incoming block.
        accept   = blk_done && (state_q == ST_IDLE) && !out_valid_q;
        sel      = snap_q[c_q];
        if (sel >= HALF_CODE) begin
            sig_d = ASCII_PLUS;
            mag   = sel - HALF_CODE;
        end else begin
            sig_d = ASCII_MINUS;
            mag   = HALF_CODE - sel;
        end
        prod = PROD_W'(mag) * PROD_W'(FS_MV);
        mv_d = MV_W'(prod >> (AD_W - 1));
    end

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt_q <= '0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                acc_q[k]  <= '0;
                snap_q[k] <= '0;
            end
        end else begin
            overrun_q <= blk_done && !accept;
            if (ad_valid) begin
                smp_cnt_q <= blk_done ? '0 : smp_cnt_q + CNT_W'(1);
                for (int k = 0; k < NCH; k++) begin
                    acc_q[k] <= blk_done ? '0 : sum_d[k];
                end
            end
            if (accept) begin
                for (int k = 0; k < NCH; k++) begin
                    snap_q[k] <= mean_d[k];
                end
            end
        end
    end

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            c_q           <= '0;
            mv_q          <= '0;
            sig_q         <= ASCII_PLUS;
            shift_first_q <= 1'b0;
            ch_dec_q      <= '0;
            out_valid_q   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                ch_sig_q[k*8 +: 8] <= ASCII_PLUS;
            end
        end else begin
            out_valid_q   <= 1'b0;
            shift_first_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_q <= ST_SNAP;
                end
                ST_SNAP: begin
                    c_q     <= '0;
                    state_q <= ST_SCALE;
                end
                ST_SCALE: begin
                    mv_q          <= mv_d;
                    sig_q         <= sig_d;
                    shift_first_q <= 1'b1;
                    state_q       <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bcd_done) state_q <= ST_STORE;
                end
                ST_STORE: begin
                    ch_dec_q[c_q*DW +: DW] <= bcd_dec;
                    ch_sig_q[c_q*8 +: 8]   <= sig_q;
                    if (c_q == CH_W'(NCH - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        c_q     <= c_q + CH_W'(1);
                        state_q <= ST_SCALE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    bcd_seq #(
        .BIN_W  (MV_W),
        .DIGITS (BCD_DIGITS)
    ) u_bcd (
        .clk_i   (ad_clk),
        .rst_n_i (rst_n),
        .start_i (shift_first_q),
        .bin_i   (mv_q),
        .done_o  (bcd_done),
        .dec_o   (bcd_dec)
    );

    assign ch_dec    = ch_dec_q;
    assign ch_sig    = ch_sig_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_volt_cal_multi.sv
// Directed bench for volt_cal_multi: three parameterisations sharing clock and reset.
module tb_volt_cal_multi;

    logic ad_clk, rst_n;

    logic        a_vld;
    logic [23:0] a_dat;
    logic [39:0] a_dec;
    logic [15:0] a_sig;
    logic        a_ov, a_busy, a_or;

    logic        b_vld;
    logic [23:0] b_dat;
    logic [39:0] b_dec;
    logic [15:0] b_sig;
    logic        b_ov, b_busy, b_or;

    logic        c_vld;
    logic [39:0] c_dat;
    logic [63:0] c_dec;
    logic [31:0] c_sig;
    logic        c_ov, c_busy, c_or;

    int n_checks = 0;
    int n_errors = 0;

    volt_cal_multi #(.NCH(2), .AD_W(12), .FS_MV(5000), .AVG_LOG2(0), .BCD_DIGITS(5)) dut_a (
        .ad_clk(ad_clk), .rst_n(rst_n), .ad_valid(a_vld), .ad_data(a_dat),
        .ch_dec(a_dec), .ch_sig(a_sig), .out_valid(a_ov), .busy(a_busy), .overrun(a_or));

    volt_cal_multi #(.NCH(2), .AD_W(12), .FS_MV(5000), .AVG_LOG2(2), .BCD_DIGITS(5)) dut_b (
        .ad_clk(ad_clk), .rst_n(rst_n), .ad_valid(b_vld), .ad_data(b_dat),
        .ch_dec(b_dec), .ch_sig(b_sig), .out_valid(b_ov), .busy(b_busy), .overrun(b_or));

    volt_cal_multi #(.NCH(4), .AD_W(10), .FS_MV(3300), .AVG_LOG2(0), .BCD_DIGITS(4)) dut_c (
        .ad_clk(ad_clk), .rst_n(rst_n), .ad_valid(c_vld), .ad_data(c_dat),
        .ch_dec(c_dec), .ch_sig(c_sig), .out_valid(c_ov), .busy(c_busy), .overrun(c_or));

    initial begin
        ad_clk = 1'b0;
        forever #5 ad_clk = ~ad_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts posedges until the selected instance shows out_valid; -1 on timeout.
    task automatic wait_ov(input int which, output int n);
        logic seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(posedge ad_clk);
            #1;
            n++;
            case (which)
                0:       seen = a_ov;
                1:       seen = b_ov;
                default: seen = c_ov;
            endcase
        end
        if (!seen) n = -1;
    endtask

    task automatic pulse_a(input logic [23:0] d);
        @(negedge ad_clk);
        a_vld = 1'b1;
        a_dat = d;
        @(negedge ad_clk);
        a_vld = 1'b0;
    endtask

    task automatic pulse_b(input logic [23:0] d);
        @(negedge ad_clk);
        b_vld = 1'b1;
        b_dat = d;
        @(negedge ad_clk);
        b_vld = 1'b0;
    endtask

    initial begin
        int n;
        int or_cnt, ov_cnt, ov_at, spur;
        logic [39:0] dec1;
        logic [15:0] sig1;

        rst_n = 1'b0;
        a_vld = 1'b0; a_dat = '0;
        b_vld = 1'b0; b_dat = '0;
        c_vld = 1'b0; c_dat = '0;
        or_cnt = 0; ov_cnt = 0; ov_at = 0; spur = 0;
        dec1 = '0; sig1 = '0;

        repeat (3) @(posedge ad_clk);
        #1;
        chk("rst_a_dec", a_dec, 40'h0);
        chk("rst_a_sig", a_sig, 16'h2B2B);
        chk("rst_a_ov", a_ov, 1'b0);
        chk("rst_a_busy", a_busy, 1'b0);
        chk("rst_a_or", a_or, 1'b0);
        chk("rst_b_sig", b_sig, 16'h2B2B);
        chk("rst_c_dec", c_dec, 64'h0);
        chk("rst_c_sig", c_sig, 32'h2B2B2B2B);
        @(negedge ad_clk);
        rst_n = 1'b1;

        // Full-scale positive and negative
        pulse_a({12'h000, 12'hFFF});
        chk("t1_busy", a_busy, 1'b1);
        wait_ov(0, n);
        chk("t1_lat", n, 31);
        chk("t1_dec", a_dec, 40'h05000_04997);
        chk("t1_sig", a_sig, 16'h2D2B);
        @(posedge ad_clk);
        #1;
        chk("t1_ov_pulse", a_ov, 1'b0);
        chk("t1_idle", a_busy, 1'b0);

        // Midscale and quarter scale
        pulse_a({12'h400, 12'h800});
        wait_ov(0, n);
        chk("t2_lat", n, 31);
        chk("t2_dec", a_dec, 40'h02500_00000);
        chk("t2_sig", a_sig, 16'h2D2B);

        // Four-sample averaging with truncation
        pulse_b({12'hC00, 12'h800});
        pulse_b({12'hC00, 12'h800});
        pulse_b({12'hC03, 12'h801});
        chk("t3_not_busy", b_busy, 1'b0);
        chk("t3_no_ov", b_ov, 1'b0);
        pulse_b({12'hC00, 12'h801});
        wait_ov(1, n);
        chk("t3_lat", n, 31);
        chk("t3_dec", b_dec, 40'h02500_00000);
        chk("t3_sig", b_sig, 16'h2B2B);

        // Continuous stream: blocks end at samples 4,8,..,40
        for (int i = 1; i <= 40; i++) begin
            @(negedge ad_clk);
            b_vld = 1'b1;
            if (i <= 36) b_dat = {12'h7FF, 12'h000};
            else         b_dat = {12'h801, ((i % 2) == 1) ? 12'hFFF : 12'hFFE};
            @(posedge ad_clk);
            #1;
            if (b_or) or_cnt++;
            if (b_ov) begin
                ov_cnt++;
                ov_at = i;
                dec1  = b_dec;
                sig1  = b_sig;
            end
        end
        @(negedge ad_clk);
        b_vld = 1'b0;
        chk("t4_overruns", or_cnt, 8);
        chk("t4_ov_count", ov_cnt, 1);
        chk("t4_ov_at", ov_at, 35);
        chk("t4_dec1", dec1, 40'h00002_05000);
        chk("t4_sig1", sig1, 16'h2D2D);
        wait_ov(1, n);
        chk("t4_lat2", n, 31);
        chk("t4_dec2", b_dec, 40'h00002_04995);
        chk("t4_sig2", b_sig, 16'h2B2B);

        // Reset in the middle of a shift phase
        pulse_a({12'h000, 12'hFFF});
        repeat (5) @(posedge ad_clk);
        #1;
        chk("t5_busy_pre", a_busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_dec", a_dec, 40'h0);
        chk("t5_sig", a_sig, 16'h2B2B);
        chk("t5_busy", a_busy, 1'b0);
        chk("t5_ov", a_ov, 1'b0);
        @(negedge ad_clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge ad_clk);
            #1;
            if (a_ov) spur++;
        end
        chk("t5_no_ov", spur, 0);
        pulse_a({12'hC00, 12'h400});
        wait_ov(0, n);
        chk("t5_lat", n, 31);
        chk("t5_dec2", a_dec, 40'h02500_02500);
        chk("t5_sig2", a_sig, 16'h2B2D);

        // Four channels, 10-bit codes, 3300 mV full scale
        @(negedge ad_clk);
        c_vld = 1'b1;
        c_dat = {10'h100, 10'h200, 10'h000, 10'h3FF};
        @(negedge ad_clk);
        c_vld = 1'b0;
        wait_ov(2, n);
        chk("t6_lat", n, 57);
        chk("t6_dec", c_dec, 64'h1650_0000_3300_3293);
        chk("t6_sig", c_sig, 32'h2D2B2D2B);
        chk("t6_no_overrun", c_or, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
